// File: rtl/fetch_pkg.sv
// Shared types and default geometry for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned DATA_WIDTH = 16;

    // Contents of the standard inst_mem.mif image: word i holds IMAGE_BASE + i.
    localparam logic [15:0] IMAGE_BASE = 16'hA000;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        VALID
    } fetch_state_t;

endpackage

// File: rtl/inst_rom.sv
// Synchronous-read instruction ROM, one cycle latency, no reset on contents or q.
module inst_rom
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = fetch_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = fetch_pkg::DATA_WIDTH,
    parameter string       INIT_FILE  = "inst_mem.mif"
) (
    input  logic                  clk_addr,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    // The default image is built in; an empty file name selects a blank ROM.
    localparam bit          HAS_IMAGE = (INIT_FILE != "");

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] = HAS_IMAGE ? DATA_WIDTH'(32'(IMAGE_BASE) + i) : '0;
        end
    end

    always_ff @(posedge clk_addr) begin
        q <= mem[addr];
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: address counter, ROM and valid/ready word output
// towards simple_processor.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = fetch_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = fetch_pkg::DATA_WIDTH,
    parameter string       INIT_FILE  = "inst_mem.mif"
) (
    input  logic                  clk_addr,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  din_ready,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] DIN,
    output logic                  din_valid,
    output logic                  done
);

    fetch_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] din_next;
    logic                  valid_next;
    logic                  done_next;
    logic [DATA_WIDTH-1:0] rom_q;

    // ROM is fed the next address so its output already matches addr by the
    // end of the single READ cycle that follows a handshake or load.
    inst_rom #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_rom (
        .clk_addr (clk_addr),
        .addr     (addr_next),
        .q        (rom_q)
    );

    always_ff @(posedge clk_addr or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            DIN       <= '0;
            din_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            addr      <= addr_next;
            DIN       <= din_next;
            din_valid <= valid_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = addr;
        din_next   = DIN;
        valid_next = din_valid;
        done_next  = 1'b0;

        if (load_en) begin
            addr_next  = load_addr;
            valid_next = 1'b0;
            state_next = enable ? READ : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    valid_next = 1'b0;
                    if (enable) state_next = READ;
                end
                READ: begin
                    din_next   = rom_q;
                    valid_next = 1'b1;
                    state_next = VALID;
                end
                VALID: begin
                    if (din_valid && din_ready) begin
                        addr_next  = addr + 1'b1;
                        valid_next = 1'b0;
                        done_next  = &addr;
                        state_next = enable ? READ : IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule
